// File: rtl/casper_tx_pkt_fifo.sv
// Store-and-forward AXIS packet FIFO feeding the DCMAC TX segment adapter; packets leave only once complete.
// Define TX_PKT_FIFO_STATS_EN to add the drop_count / fwd_count statistics outputs.
module casper_tx_pkt_fifo #(
  parameter int DATA_WIDTH    = 1024,
  parameter int DEPTH         = 64,
  parameter int MAX_PKT_BEATS = DEPTH - 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tuser,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [7:0]              pkt_count
`ifdef TX_PKT_FIFO_STATS_EN
  ,
  output logic [31:0]             drop_count,
  output logic [31:0]             fwd_count
`endif
);

  localparam int KEEP_WIDTH = DATA_WIDTH / 8;
  localparam int AW         = $clog2(DEPTH);
  localparam int PW         = AW + 1;
  localparam int WW         = DATA_WIDTH + KEEP_WIDTH + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] MAX_P   = PW'(MAX_PKT_BEATS);

  typedef enum logic [1:0] {IDLE, WRITE, DROP} wr_state_e;

  logic [WW-1:0] mem [DEPTH];
  logic [WW-1:0] mem_q;
  logic          mem_q_valid;
  wr_state_e     state;
  logic [PW-1:0] wr_ptr, wr_commit, rd_ptr, rd_addr, pkt_start, len;
  logic [PW-1:0] len_next, start;
  logic          full, empty, s_fire, wr_en;
  logic          commit_evt, bad_evt, over_evt, deadlock;
  logic          commit_q, pkt_done;
  logic          out_load, mem_adv, rd_en;

  // rd_ptr advances only when a beat leaves m_axis, so the pipeline registers count against capacity.
  assign full     = (wr_ptr - rd_ptr) == DEPTH_P;
  assign empty    = rd_ptr == wr_commit;
  assign deadlock = (state == WRITE) && full && empty;

  always_comb begin
    s_axis_tready = 1'b0; // NOTE: default first so every path assigns and no latch is inferred
    if (!rst) begin
      if (state == DROP) s_axis_tready = 1'b1;
      else               s_axis_tready = !full;
    end
  end

  assign s_fire     = s_axis_tvalid && s_axis_tready;
  assign wr_en      = s_fire && (state != DROP);
  assign len_next   = (state == IDLE) ? PW'(1) : len + 1'b1;
  assign start      = (state == IDLE) ? wr_ptr : pkt_start;
  assign commit_evt = wr_en && s_axis_tlast && !s_axis_tuser;
  assign bad_evt    = wr_en && s_axis_tlast && s_axis_tuser;
  assign over_evt   = wr_en && !s_axis_tlast && (len_next >= MAX_P);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      wr_commit <= '0;
      pkt_start <= '0;
      len       <= '0;
      commit_q  <= 1'b0;
    end else begin
      commit_q <= commit_evt;
      case (state)
        IDLE, WRITE: begin
          if (deadlock) begin
            wr_ptr <= pkt_start;
            state  <= DROP;
          end else if (wr_en) begin
            pkt_start <= start;
            len       <= len_next;
            if (commit_evt) begin
              wr_ptr    <= wr_ptr + 1'b1;
              wr_commit <= wr_ptr + 1'b1;
              state     <= IDLE;
            end else if (bad_evt) begin
              wr_ptr <= start;
              state  <= IDLE;
            end else if (over_evt) begin
              wr_ptr <= start;
              state  <= DROP;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
              state  <= WRITE;
            end
          end
        end
        DROP:    if (s_fire && s_axis_tlast) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the storage array and its read register carry no reset; valid flags guard their contents
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
    if (rd_en) mem_q <= mem[rd_addr[AW-1:0]];
  end

  // Two-stage read: RAM register then output register, both advancing together when not stalled.
  assign out_load = mem_q_valid && (!m_axis_tvalid || m_axis_tready);
  assign mem_adv  = !mem_q_valid || out_load;
  assign rd_en    = (rd_addr != wr_commit) && mem_adv;
  assign pkt_done = m_axis_tvalid && m_axis_tready && m_axis_tlast;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_addr       <= '0;
      rd_ptr        <= '0;
      mem_q_valid   <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tkeep  <= '0;
      m_axis_tdata  <= '0;
    end else begin
      if (rd_en) rd_addr <= rd_addr + 1'b1;
      if (m_axis_tvalid && m_axis_tready) rd_ptr <= rd_ptr + 1'b1;
      if (mem_adv) mem_q_valid <= rd_en;
      if (out_load) begin
        {m_axis_tlast, m_axis_tkeep, m_axis_tdata} <= mem_q;
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count <= '0;
    end else if (commit_q && !pkt_done) begin
      if (pkt_count != 8'hFF) pkt_count <= pkt_count + 1'b1;
    end else if (!commit_q && pkt_done) begin
      if (pkt_count != 8'h00) pkt_count <= pkt_count - 1'b1;
    end
  end

`ifdef TX_PKT_FIFO_STATS_EN
  logic drop_evt;
  assign drop_evt = bad_evt || over_evt || deadlock;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count <= '0;
      fwd_count  <= '0;
    end else begin
      if (drop_evt) drop_count <= drop_count + 1'b1;
      if (pkt_done) fwd_count  <= fwd_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_casper_tx_pkt_fifo.sv
// Directed bench for casper_tx_pkt_fifo: latency, oversize/bad drops, full stall, random backpressure, reset.
// Statistics checks are compiled in when TX_PKT_FIFO_STATS_EN is defined.
module tb_casper_tx_pkt_fifo;

  localparam int DW = 1024;
  localparam int KW = DW / 8;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic          user;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [KW-1:0] s_axis_tkeep = '0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tuser = 1'b0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic [7:0]    pkt_count;
`ifdef TX_PKT_FIFO_STATS_EN
  logic [31:0]   drop_count;
  logic [31:0]   fwd_count;
`endif

  casper_tx_pkt_fifo dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .pkt_count     (pkt_count)
`ifdef TX_PKT_FIFO_STATS_EN
    ,
    .drop_count    (drop_count),
    .fwd_count     (fwd_count)
`endif
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_errors = 0;
  int    seq = 0;
  beat_t src_q[$];
  beat_t exp_q[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_data(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed low %h expected low %h", tag, obs[63:0], exp[63:0]);
    end
  endtask

  function automatic logic [DW-1:0] mk_data(input logic [31:0] v);
    return {32{v}};
  endfunction

  // Queue a packet on the source; 'expect_out' says whether it must reappear on m_axis.
  task automatic add_pkt(input int nbeats, input bit bad, input logic [KW-1:0] last_keep,
                         input bit expect_out);
    beat_t b;
    for (int i = 0; i < nbeats; i++) begin
      seq++;
      b.data = mk_data(seq * 32'h9E3779B1);
      b.last = (i == nbeats - 1);
      b.keep = b.last ? last_keep : '1;
      b.user = b.last && bad;
      src_q.push_back(b);
      if (expect_out) exp_q.push_back(b);
    end
  endtask

  task automatic drive_front();
    s_axis_tdata  = src_q[0].data;
    s_axis_tkeep  = src_q[0].keep;
    s_axis_tlast  = src_q[0].last;
    s_axis_tuser  = src_q[0].user;
    s_axis_tvalid = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    src_q.delete();
    exp_q.delete();
    repeat (2) @(negedge clk);
    check("rst_m_tvalid", m_axis_tvalid, 0);
    check("rst_m_tlast", m_axis_tlast, 0);
    check("rst_m_tkeep", m_axis_tkeep, 0);
    check("rst_pkt_count", pkt_count, 0);
    check("rst_s_tready", s_axis_tready, 0);
    check_data("rst_m_tdata", m_axis_tdata, '0);
    rst = 1'b0;
  endtask

  // Drive src_q and consume m_axis against exp_q. mode 0: tready always 1; otherwise random 50%.
  task automatic run(input int mode, input int budget, output int stalls);
    int    cyc = 0;
    bit    r;
    bit    in_pkt = 1'b0;
    bit    held = 1'b0;
    beat_t hb;
    beat_t e;
    stalls = 0;
    forever begin
      @(negedge clk);
      if (held) begin
        check("hold_valid", m_axis_tvalid, 1);
        check_data("hold_data", m_axis_tdata, hb.data);
        check("hold_keep", m_axis_tkeep, hb.keep);
        check("hold_last", m_axis_tlast, hb.last);
      end else if (in_pkt) begin
        check("no_bubble", m_axis_tvalid, 1);
      end
      r = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      m_axis_tready = r;
      if (m_axis_tvalid && r) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid", m_axis_tvalid, 0);
        end else begin
          e = exp_q.pop_front();
          check_data("out_data", m_axis_tdata, e.data);
          check("out_keep", m_axis_tkeep, e.keep);
          check("out_last", m_axis_tlast, e.last);
          in_pkt = !e.last;
        end
      end
      held = m_axis_tvalid && !r;
      if (held) begin
        hb.data = m_axis_tdata;
        hb.keep = m_axis_tkeep;
        hb.last = m_axis_tlast;
      end
      if (src_q.size() != 0) begin
        drive_front();
        if (s_axis_tready) void'(src_q.pop_front());
        else               stalls++;
      end else begin
        s_axis_tvalid = 1'b0;
      end
      cyc++;
      if (src_q.size() == 0 && exp_q.size() == 0 && !s_axis_tvalid) break;
      if (cyc >= budget) begin
        check("timeout_left", src_q.size() + exp_q.size(), 0);
        s_axis_tvalid = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    int stalls;
    int acc;
    logic [KW-1:0] k;

    // 1: single 4-beat packet, latency and pkt_count
    do_reset();
    add_pkt(4, 1'b0, 128'hFFFF, 1'b1);
    for (int i = 0; i < 20 && src_q.size() != 0; i++) begin
      @(negedge clk);
      drive_front();
      if (s_axis_tready) void'(src_q.pop_front());
    end
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    check("t1_valid_c1", m_axis_tvalid, 0);
    check("t1_count_c1", pkt_count, 0);
    @(negedge clk);
    check("t1_valid_c2", m_axis_tvalid, 0);
    check("t1_count_c2", pkt_count, 1);
    @(negedge clk);
    check("t1_valid_c3", m_axis_tvalid, 1);
    run(0, 50, stalls);
    @(negedge clk);
    check("t1_count_end", pkt_count, 0);
    check("t1_valid_end", m_axis_tvalid, 0);

    // 2: oversize packet dropped whole, following packet passes
    do_reset();
    add_pkt(64, 1'b0, '1, 1'b0);
    add_pkt(2, 1'b0, 128'hF, 1'b1);
    run(0, 200, stalls);
    check("t2_no_stall", stalls, 0);
`ifdef TX_PKT_FIFO_STATS_EN
    check("t2_drop_count", drop_count, 1);
`endif

    // 3: bad packet rewound, then a good packet
    do_reset();
    add_pkt(3, 1'b1, '1, 1'b0);
    run(0, 50, stalls);
    repeat (3) @(negedge clk);
    check("t3_wr_ptr", dut.wr_ptr, 0);
    check("t3_count", pkt_count, 0);
    check("t3_valid", m_axis_tvalid, 0);
    add_pkt(3, 1'b0, 128'h3, 1'b1);
    run(0, 50, stalls);
`ifdef TX_PKT_FIFO_STATS_EN
    check("t3_drop_count", drop_count, 1);
`endif

    // 4: fill with m_axis_tready low, then drain
    do_reset();
    for (int p = 0; p < 14; p++) add_pkt(5, 1'b0, '1, 1'b1);
    acc = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      m_axis_tready = 1'b0;
      if (src_q.size() != 0) begin
        drive_front();
        if (s_axis_tready) begin
          void'(src_q.pop_front());
          acc++;
        end
      end
    end
    check("t4_accepted", acc, 64);
    check("t4_s_tready", s_axis_tready, 0);
    check("t4_count", pkt_count, 12);
    check("t4_valid", m_axis_tvalid, 1);
    check_data("t4_head", m_axis_tdata, exp_q[0].data);
    run(0, 200, stalls);

    // 5: random lengths with random backpressure
    do_reset();
    for (int p = 0; p < 100; p++) begin
      k = (128'h1 << $urandom_range(1, 128)) - 1'b1;
      add_pkt($urandom_range(1, 40), 1'b0, k, 1'b1);
    end
    run(1, 20000, stalls);
`ifdef TX_PKT_FIFO_STATS_EN
    check("t5_fwd_count", fwd_count, 100);
    check("t5_drop_count", drop_count, 0);
`endif

    // 6: reset while one packet is being read and another is half written
    do_reset();
    add_pkt(4, 1'b0, '1, 1'b0);
    add_pkt(5, 1'b0, '1, 1'b0);
    acc = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      m_axis_tready = 1'b1;
      if (acc == 7) break;
      drive_front();
      if (s_axis_tready) begin
        void'(src_q.pop_front());
        acc++;
      end
    end
    check("t6_pre_valid", m_axis_tvalid, 1);
    check("t6_pre_count", pkt_count, 1);
    s_axis_tvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("t6_valid", m_axis_tvalid, 0);
    check("t6_count", pkt_count, 0);
    rst = 1'b0;
    src_q.delete();
    exp_q.delete();
    add_pkt(3, 1'b0, 128'hFF, 1'b1);
    run(0, 50, stalls);
    @(negedge clk);
    check("t6_count_end", pkt_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
